dram_ctrl_param: RTL and testbench
==================================

Name: dram_ctrl_param

Overview:
Parametrised asynchronous-DRAM controller; next generation of the fixed RAS/MUX/CAS sequencer. Adds configurable timing, row/column address multiplexing, read/write, an ack/busy handshake, and CAS-before-RAS (CBR) refresh generated internally. Sits between a single bus requester and the DRAM pins.

Parameters:
ADDR_W, 8, DRAM multiplexed address width; addr_in is 2*ADDR_W (row = upper half, col = lower half)
T_RCD, 1, cycles RAS low with mux=0 before mux switches to column
T_CSD, 1, cycles mux=1 with CAS high before CAS falls
T_CAS, 2, cycles CAS held low
T_RP, 2, precharge cycles (RAS and CAS high) after every access or refresh
T_REF, 2, cycles RAS low during CBR refresh
REF_PERIOD, 64, cycles between refresh requests

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_n_in  input  1  asynchronous active-low reset
req_in  input  1  access request, level, sampled in IDLE only
we_in  input  1  1 = write, 0 = read; captured with request
addr_in  input  2*ADDR_W  {row, col}; captured with request
ack_out  output  1  one-cycle pulse in last CAS-low cycle of an access
busy_out  output  1  high whenever state != IDLE
ras_out  output  1  DRAM RAS, active low
cas_out  output  1  DRAM CAS, active low
mux_out  output  1  0 = row on dram_addr_out, 1 = column
we_n_out  output  1  DRAM WE, active low
dram_addr_out  output  ADDR_W  multiplexed row/column address

Behaviour:
- Reset (async, rst_n_in low): state IDLE; ras_out=1, cas_out=1, mux_out=0, we_n_out=1, ack_out=0, busy_out=0, dram_addr_out=0; refresh counter=0, ref_pending=0. Takes effect mid-operation immediately; interrupted access gets no ack.
- All outputs registered; values below are those visible after the named edge.
- States: IDLE, ROW, COL, CAS, PRE, REF_CAS, REF_RAS. A per-state down-counter sized for the largest T_* sets dwell time.
- IDLE: ras=1 cas=1 mux=0 we_n=1. At edge with ref_pending=1 -> REF_CAS (refresh wins over simultaneous req). Else if req_in=1 -> latch addr_in/we_in, -> ROW. Else stay.
- ROW (T_RCD cycles): ras=0, mux=0, cas=1, dram_addr=row, we_n=~we.
- COL (T_CSD cycles): ras=0, mux=1, cas=1, dram_addr=col.
- CAS (T_CAS cycles): ras=0, mux=1, cas=0; ack_out=1 in final cycle only. Then -> PRE.
- PRE (T_RP cycles): ras=1, cas=1, mux=0, we_n=1; then -> IDLE.
- REF_CAS (1 cycle): cas=0, ras=1; ref_pending cleared on entry. REF_RAS (T_REF cycles): cas=0, ras=0. Then -> PRE. No ack.
- Refresh timer free-runs in every state; at count REF_PERIOD-1 sets ref_pending and wraps to 0. A second tick while pending is absorbed (no stacking).
- req_in while busy is ignored; held req_in after ack starts a new access on return to IDLE. Requester drops req in the cycle after ack for a single access.
- Default access: 1+1+2 cycles active, ack on 4th, +2 precharge; busy 6 cycles.
- All T_* >= 1; REF_PERIOD > T_RCD+T_CSD+T_CAS+T_RP+T_REF+1 (checked by elaboration-time assertion).

Decomposition:
- Shared package/header dram_ctrl_pkg: state encoding constants, default timing constants.
- Sub-module dram_refresh_timer (REF_PERIOD counter + ref_pending, clear input); main FSM in dram_ctrl_param.

Test Plan:
- Defaults, read, addr_in=16'hA55A, req high one cycle: edges 1..4 give (ras,mux,cas)=(0,0,1),(0,1,1),(0,1,0),(0,1,0); dram_addr A5 then 5A; ack only at edge 4; ras high edges 5-6; busy low after edge 6.
- Write, we_in=1: we_n_out=0 from ROW through CAS, 1 in PRE; same ack timing as read.
- Idle 64 cycles: cas falls one cycle before ras, ras low 2 cycles, then 2 precharge; ack never asserted; repeats every 64 cycles.
- req_in rises same edge ref_pending set: refresh (1+2+2 cycles) runs first, access starts next edge, ack 4 cycles later; address captured then is used.
- Reset asserted during CAS: ras=cas=1, mux=0, busy=0 immediately, no ack; after release, default read produces exact sequence of first scenario.
- ADDR_W=10, T_CAS=3, T_RP=1: CAS low exactly 3 cycles, ack in 3rd, single precharge cycle, 10-bit row/col presented correctly.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// Shared state encoding and default timing for the async-DRAM controller.
package dram_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ROW     = 3'd1,
    S_COL     = 3'd2,
    S_CAS     = 3'd3,
    S_PRE     = 3'd4,
    S_REF_CAS = 3'd5,
    S_REF_RAS = 3'd6
  } state_t;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_T_RCD      = 1;
  localparam int DEF_T_CSD      = 1;
  localparam int DEF_T_CAS      = 2;
  localparam int DEF_T_RP       = 2;
  localparam int DEF_T_REF      = 2;
  localparam int DEF_REF_PERIOD = 64;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter; raises pending each period until cleared.
module dram_refresh_timer
  import dram_ctrl_pkg::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic pending
);

  localparam int CW = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;

  logic [CW-1:0] count;
  logic          tick;

  assign tick = (count == CW'(REF_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      pending <= 1'b0;
    end else begin
      count <= tick ? '0 : count + 1'b1;
      // a tick while already pending is absorbed; set wins over clear
      if (tick)
        pending <= 1'b1;
      else if (clear)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_ctrl_param.sv
// RAS/MUX/CAS access sequencer with internal CAS-before-RAS refresh.
//  state     | meaning
//  IDLE      | waiting for refresh or request
//  ROW       | RAS low, row address on pins
//  COL       | column address on pins, CAS still high
//  CAS       | CAS low, ack in last cycle
//  PRE       | RAS/CAS high precharge
//  REF_CAS   | CAS low ahead of RAS (CBR)
//  REF_RAS   | CAS and RAS low for refresh
module dram_ctrl_param
  import dram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int T_RCD      = DEF_T_RCD,
  parameter int T_CSD      = DEF_T_CSD,
  parameter int T_CAS      = DEF_T_CAS,
  parameter int T_RP       = DEF_T_RP,
  parameter int T_REF      = DEF_T_REF,
  parameter int REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  req_in,
  input  logic                  we_in,
  input  logic [2*ADDR_W-1:0]   addr_in,
  output logic                  ack_out,
  output logic                  busy_out,
  output logic                  ras_out,
  output logic                  cas_out,
  output logic                  mux_out,
  output logic                  we_n_out,
  output logic [ADDR_W-1:0]     dram_addr_out
);

  localparam int T_MAX = max_of(max_of(max_of(T_RCD, T_CSD), max_of(T_CAS, T_RP)), T_REF);
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  if (T_RCD < 1 || T_CSD < 1 || T_CAS < 1 || T_RP < 1 || T_REF < 1 ||
      REF_PERIOD <= T_RCD + T_CSD + T_CAS + T_RP + T_REF + 1) begin : g_param_check
    $error("dram_ctrl_param: illegal timing parameters");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  col_q;
  logic               ref_pending;
  logic               ref_clear;

  assign ref_clear = (state == S_IDLE) && ref_pending;

  dram_refresh_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .clear   (ref_clear),
    .pending (ref_pending)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= S_IDLE;
      cnt           <= '0;
      col_q         <= '0;
      ack_out       <= 1'b0;
      busy_out      <= 1'b0;
      ras_out       <= 1'b1;
      cas_out       <= 1'b1;
      mux_out       <= 1'b0;
      we_n_out      <= 1'b1;
      dram_addr_out <= '0;
    end else begin
      ack_out <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ref_pending) begin
            state    <= S_REF_CAS;
            cnt      <= '0;
            cas_out  <= 1'b0;
            busy_out <= 1'b1;
          end else if (req_in) begin
            state         <= S_ROW;
            cnt           <= CNT_W'(T_RCD - 1);
            col_q         <= addr_in[ADDR_W-1:0];
            dram_addr_out <= addr_in[2*ADDR_W-1:ADDR_W];
            we_n_out      <= ~we_in;
            ras_out       <= 1'b0;
            busy_out      <= 1'b1;
          end
        end
        S_ROW: begin
          if (cnt == '0) begin
            state         <= S_COL;
            cnt           <= CNT_W'(T_CSD - 1);
            mux_out       <= 1'b1;
            dram_addr_out <= col_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_COL: begin
          if (cnt == '0) begin
            state   <= S_CAS;
            cnt     <= CNT_W'(T_CAS - 1);
            cas_out <= 1'b0;
            ack_out <= (T_CAS == 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_CAS: begin
          if (cnt == '0) begin
            state    <= S_PRE;
            cnt      <= CNT_W'(T_RP - 1);
            ras_out  <= 1'b1;
            cas_out  <= 1'b1;
            mux_out  <= 1'b0;
            we_n_out <= 1'b1;
          end else begin
            cnt     <= cnt - 1'b1;
            // ack registers so it is visible during the final CAS-low cycle
            ack_out <= (cnt == CNT_W'(1));
          end
        end
        S_PRE: begin
          if (cnt == '0) begin
            state    <= S_IDLE;
            busy_out <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_REF_CAS: begin
          state   <= S_REF_RAS;
          cnt     <= CNT_W'(T_REF - 1);
          ras_out <= 1'b0;
        end
        S_REF_RAS: begin
          if (cnt == '0) begin
            state   <= S_PRE;
            cnt     <= CNT_W'(T_RP - 1);
            ras_out <= 1'b1;
            cas_out <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ctrl_param.sv
// Directed bench: default instance plus an ADDR_W=10/T_CAS=3/T_RP=1 instance.
module tb_dram_ctrl_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr1 = '0;
  logic        ack1, busy1, ras1, cas1, mux1, wen1;
  logic [7:0]  da1;

  logic        req2 = 1'b0, we2 = 1'b0;
  logic [19:0] addr2 = '0;
  logic        ack2, busy2, ras2, cas2, mux2, wen2;
  logic [9:0]  da2;

  dram_ctrl_param dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req1), .we_in(we1), .addr_in(addr1),
    .ack_out(ack1), .busy_out(busy1), .ras_out(ras1), .cas_out(cas1),
    .mux_out(mux1), .we_n_out(wen1), .dram_addr_out(da1)
  );

  dram_ctrl_param #(.ADDR_W(10), .T_CAS(3), .T_RP(1)) dut2 (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req2), .we_in(we2), .addr_in(addr2),
    .ack_out(ack2), .busy_out(busy2), .ras_out(ras2), .cas_out(cas2),
    .mux_out(mux2), .we_n_out(wen2), .dram_addr_out(da2)
  );

  typedef struct {
    int          sel;
    logic        we;
    logic [19:0] addr;
    logic [9:0]  row;
    logic [9:0]  col;
  } vec_t;

  vec_t vecs[8];
  int tests = 0;
  int fails = 0;

  // pin vector order: {ras, mux, cas, we_n, ack, busy}
  localparam logic [5:0] P_IDLE = 6'b101100;
  localparam logic [5:0] P_PRE  = 6'b101101;

  function automatic logic [5:0] pins(input int sel);
    if (sel == 0) return {ras1, mux1, cas1, wen1, ack1, busy1};
    return {ras2, mux2, cas2, wen2, ack2, busy2};
  endfunction

  function automatic logic [9:0] addr_of(input int sel);
    if (sel == 0) return {2'b00, da1};
    return da2;
  endfunction

  function automatic logic [5:0] exp_access(input int e, input int tc, input int trp, input logic we);
    if (e == 1) return {3'b001, ~we, 2'b01};
    if (e == 2) return {3'b011, ~we, 2'b01};
    if (e <= 2 + tc) return {3'b010, ~we, (e == 2 + tc), 1'b1};
    if (e <= 2 + tc + trp) return P_PRE;
    return P_IDLE;
  endfunction

  function automatic logic [5:0] exp_ref(input int m);
    if (m == 1) return 6'b100101;
    if (m == 2 || m == 3) return 6'b000101;
    if (m == 4 || m == 5) return P_PRE;
    return P_IDLE;
  endfunction

  task automatic check(input string name, input int idx, input logic [9:0] got, input logic [9:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req1 = 1'b0;
    req2 = 1'b0;
    @(negedge clk);
    check("reset_pins1", 0, {4'b0, pins(0)}, {4'b0, P_IDLE});
    check("reset_pins2", 0, {4'b0, pins(1)}, {4'b0, P_IDLE});
    check("reset_addr1", 0, addr_of(0), 10'h000);
    check("reset_addr2", 0, addr_of(1), 10'h000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_access(input vec_t v);
    int tc = (v.sel == 0) ? 2 : 3;
    int trp = (v.sel == 0) ? 2 : 1;
    int n = 3 + tc + trp;
    if (v.sel == 0) begin
      addr1 = v.addr[15:0]; we1 = v.we; req1 = 1'b1;
    end else begin
      addr2 = v.addr; we2 = v.we; req2 = 1'b1;
    end
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1) begin
        req1 = 1'b0;
        req2 = 1'b0;
      end
      check("access_pins", e, {4'b0, pins(v.sel)}, {4'b0, exp_access(e, tc, trp, v.we)});
      if (e == 1)
        check("access_row", e, addr_of(v.sel), v.row);
      else if (e <= 2 + tc)
        check("access_col", e, addr_of(v.sel), v.col);
    end
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 20'h0A55A, 10'h0A5, 10'h05A};
    vecs[1] = '{0, 1'b1, 20'h0A55A, 10'h0A5, 10'h05A};
    vecs[2] = '{0, 1'b0, 20'h000FF, 10'h000, 10'h0FF};
    vecs[3] = '{0, 1'b1, 20'h0FF00, 10'h0FF, 10'h000};
    vecs[4] = '{0, 1'b0, 20'h03C81, 10'h03C, 10'h081};
    vecs[5] = '{1, 1'b0, 20'hA955A, 10'h2A5, 10'h15A};
    vecs[6] = '{1, 1'b1, 20'hFFC01, 10'h3FF, 10'h001};
    vecs[7] = '{1, 1'b0, 20'h803FE, 10'h200, 10'h3FE};

    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_access(vecs[i]);
    end

    // idle refresh: CBR every 64 cycles, never an ack
    do_reset();
    for (int k = 1; k <= 140; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("idle_refresh", k, {4'b0, pins(0)}, {4'b0, (k > 64) ? exp_ref(k % 64) : P_IDLE});
    end

    // request appears together with ref_pending: refresh first, then access
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    addr1 = 16'h1234; we1 = 1'b0; req1 = 1'b1;
    for (int k = 65; k <= 77; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 70)
        check("collide_pins", k, {4'b0, pins(0)}, {4'b0, exp_ref(k - 64)});
      else
        check("collide_pins", k, {4'b0, pins(0)}, {4'b0, exp_access(k - 70, 2, 2, 1'b0)});
      if (k == 71) check("collide_row", k, addr_of(0), 10'h0C3);
      if (k >= 72 && k <= 74) check("collide_col", k, addr_of(0), 10'h0E7);
      if (k == 67) addr1 = 16'hC3E7;
      if (k == 71) req1 = 1'b0;
    end

    // reset in the middle of CAS
    do_reset();
    addr1 = 16'hA55A; we1 = 1'b0; req1 = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1) req1 = 1'b0;
    end
    check("midcas_before", 3, {4'b0, pins(0)}, {4'b0, exp_access(3, 2, 2, 1'b0)});
    rst_n = 1'b0;
    #1;
    check("midcas_reset", 0, {4'b0, pins(0)}, {4'b0, P_IDLE});
    @(posedge clk);
    @(negedge clk);
    check("midcas_noack", 1, {4'b0, pins(0)}, {4'b0, P_IDLE});
    rst_n = 1'b1;
    run_access(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
